// File: rtl/seg_display_driver.sv
// Two-digit seven-segment driver: valid/ready byte intake, PWM-boundary apply, hex glyphs with PWM
// brightness, leading-zero blanking and decimal points. Optional blink gated by SEG_DISPLAY_BLINK_EN.
module seg_display_driver #(
   parameter int unsigned PWM_W      = 4,
   parameter int unsigned BLINK_HALF = 25000000
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [7:0]       data_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [PWM_W-1:0] bright_i,
   input  logic             blank_lz_i,
   input  logic [1:0]       dp_i,
   input  logic             blink_i,
   output logic [7:0]       hg0_o,
   output logic [7:0]       hg1_o
);

   localparam logic [PWM_W-1:0] PWM_MAX = {PWM_W{1'b1}};

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h6F;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         4'hF:    g = 7'h71;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   logic [7:0]       r_pend;
   logic             r_pend_vld;
   logic [7:0]       r_shown;
   logic [PWM_W-1:0] r_pwm_cnt;
   logic [7:0]       r_hg0;
   logic [7:0]       r_hg1;
   logic             w_lit;
   logic             w_lz;
   logic             w_blank;
   logic [7:0]       w_hg0_nxt;
   logic [7:0]       w_hg1_nxt;

   assign ready_o = ~r_pend_vld;
   assign hg0_o   = r_hg0;
   assign hg1_o   = r_hg1;

   // Handshake intake, wrap-aligned apply and free-running PWM counter
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pend     <= 8'h00;
         r_pend_vld <= 1'b0;
         r_shown    <= 8'h00;
         r_pwm_cnt  <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
         if (r_pend_vld) begin
            // Only swap the shown byte at the wrap so a period is never torn
            if (r_pwm_cnt == PWM_MAX) begin
               r_shown    <= r_pend;
               r_pend_vld <= 1'b0;
            end
         end else if (valid_i) begin
            r_pend     <= data_i;
            r_pend_vld <= 1'b1;
         end
      end
   end

`ifdef SEG_DISPLAY_BLINK_EN
   localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_on;

   // Blink half-period counter; phase flips every BLINK_HALF cycles
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
         r_blink_cnt <= '0;
         r_blink_on  <= ~r_blink_on;
      end else begin
         r_blink_cnt <= r_blink_cnt + BW'(1);
      end
   end

   assign w_blank = blink_i & ~r_blink_on;
`else
   logic w_unused;

   assign w_unused = blink_i ^ BLINK_HALF[0];
   assign w_blank  = 1'b0;
`endif

   // Next-state glyph/brightness decode for both digits
   always_comb begin
      w_lit     = (bright_i == PWM_MAX) || (r_pwm_cnt < bright_i);
      w_lz      = blank_lz_i && (r_shown[7:4] == 4'h0);
      w_hg0_nxt = 8'h00;
      w_hg1_nxt = 8'h00;
      if (w_blank) begin
         w_hg0_nxt = 8'h00;
         w_hg1_nxt = 8'h00;
      end else if (w_lit) begin
         w_hg0_nxt = {dp_i[0], glyph(r_shown[3:0])};
         w_hg1_nxt = {dp_i[1], (w_lz ? 7'h00 : glyph(r_shown[7:4]))};
      end else begin
         w_hg0_nxt = 8'h00;
         w_hg1_nxt = 8'h00;
      end
   end

   // Registered segment outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_hg0 <= 8'h00;
         r_hg1 <= 8'h00;
      end else begin
         r_hg0 <= w_hg0_nxt;
         r_hg1 <= w_hg1_nxt;
      end
   end

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: vector table, hand sequences and a randomized run,
// all compared each cycle against a cycle-count based reference model.
module tb_seg_display_driver;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b1;
   logic [7:0] data_i = 8'h00;
   logic       valid_i = 1'b0;
   logic       ready_o;
   logic [3:0] bright_i = 4'hF;
   logic       blank_lz_i = 1'b0;
   logic [1:0] dp_i = 2'b00;
   logic       blink_i = 1'b0;
   logic [7:0] hg0_o;
   logic [7:0] hg1_o;

   int total = 0;
   int bad = 0;

   // reference model: cycles since reset release, shown byte, pending queue
   int         cyc = 0;
   logic [7:0] m_shown = 8'h00;
   logic [7:0] m_q[$];
   logic [6:0] G[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      logic [7:0] data;
      logic [3:0] bright;
      logic [1:0] dp;
      logic       blz;
      logic [7:0] e0;
      logic [7:0] e1;
   } vec_t;

   vec_t vecs[10];

   seg_display_driver #(.PWM_W(4), .BLINK_HALF(8)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
      .ready_o(ready_o), .bright_i(bright_i), .blank_lz_i(blank_lz_i), .dp_i(dp_i),
      .blink_i(blink_i), .hg0_o(hg0_o), .hg1_o(hg1_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      cyc     = 0;
      m_shown = 8'h00;
      m_q.delete();
   endtask

   // one clock: predict outputs, advance model at posedge, compare at negedge
   task automatic cycle();
      logic       lit;
      logic       lz;
      logic [7:0] e0;
      logic [7:0] e1;
      lit = (bright_i == 4'hF) || ((cyc % 16) < int'(bright_i));
      lz  = blank_lz_i && (m_shown[7:4] == 4'h0);
      e0  = lit ? {dp_i[0], G[m_shown[3:0]]} : 8'h00;
      e1  = lit ? {dp_i[1], (lz ? 7'h00 : G[m_shown[7:4]])} : 8'h00;
`ifdef SEG_DISPLAY_BLINK_EN
      if (blink_i && ((cyc / 8) % 2 == 1)) begin
         e0 = 8'h00;
         e1 = 8'h00;
      end
`endif
      @(posedge clk_i);
      if (m_q.size() != 0 && (cyc % 16) == 15) m_shown = m_q.pop_front();
      else if (m_q.size() == 0 && valid_i) m_q.push_back(data_i);
      cyc++;
      @(negedge clk_i);
      check("hg0", hg0_o, e0);
      check("hg1", hg1_o, e1);
      check("ready", {7'h00, ready_o}, {7'h00, (m_q.size() == 0)});
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (ready_o !== 1'b1 && n < 40) begin
         cycle();
         n++;
      end
      check("wait_ready", {7'h00, ready_o}, 8'h01);
   endtask

   task automatic load(input logic [7:0] d);
      wait_ready();
      data_i  = d;
      valid_i = 1'b1;
      cycle();
      valid_i = 1'b0;
      wait_ready();
      cycle();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int cnt;

      vecs[0] = '{8'h3A, 4'hF, 2'b00, 1'b0, 8'h77, 8'h4F};
      vecs[1] = '{8'h05, 4'hF, 2'b10, 1'b1, 8'h6D, 8'h80};
      vecs[2] = '{8'h05, 4'hF, 2'b00, 1'b0, 8'h6D, 8'h3F};
      vecs[3] = '{8'h00, 4'hF, 2'b11, 1'b1, 8'hBF, 8'h80};
      vecs[4] = '{8'hF0, 4'hF, 2'b01, 1'b1, 8'hBF, 8'h71};
      vecs[5] = '{8'hC7, 4'hF, 2'b00, 1'b0, 8'h07, 8'h39};
      vecs[6] = '{8'hE9, 4'hF, 2'b10, 1'b0, 8'h6F, 8'hF9};
      vecs[7] = '{8'h88, 4'h0, 2'b11, 1'b0, 8'h00, 8'h00};
      vecs[8] = '{8'h4B, 4'hF, 2'b00, 1'b1, 8'h7C, 8'h66};
      vecs[9] = '{8'hD2, 4'hF, 2'b01, 1'b0, 8'hDB, 8'h5E};

      // power-on reset, checked before any clock edge
      #2 rst_n_i = 1'b0;
      #1;
      check("rst_hg0", hg0_o, 8'h00);
      check("rst_hg1", hg1_o, 8'h00);
      check("rst_ready", {7'h00, ready_o}, 8'h01);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      model_reset();

      // accept 0x3A so that pwm_cnt reads 5 once ready_o has dropped
      while ((cyc % 16) != 4) cycle();
      data_i  = 8'h3A;
      valid_i = 1'b1;
      cycle();
      valid_i = 1'b0;
      n = 0;
      while (ready_o === 1'b0 && n < 40) begin
         n++;
         cycle();
      end
      check("ready_low_cycles", 8'(n), 8'd11);
      cycle();
      check("apply_hg1", hg1_o, 8'h4F);
      check("apply_hg0", hg0_o, 8'h77);

      // backpressure: 0x22 offered while 0x11 pends
      wait_ready();
      data_i  = 8'h11;
      valid_i = 1'b1;
      cycle();
      data_i  = 8'h22;
      wait_ready();
      cycle();
      check("bp_first_hg0", hg0_o, 8'h06);
      check("bp_first_hg1", hg1_o, 8'h06);
      valid_i = 1'b0;
      wait_ready();
      cycle();
      check("bp_second_hg0", hg0_o, 8'h5B);
      check("bp_second_hg1", hg1_o, 8'h5B);

      // reset mid-stream with a byte pending
      data_i  = 8'h77;
      valid_i = 1'b1;
      cycle();
      valid_i = 1'b0;
      #2 rst_n_i = 1'b0;
      #1;
      check("midrst_hg0", hg0_o, 8'h00);
      check("midrst_hg1", hg1_o, 8'h00);
      check("midrst_ready", {7'h00, ready_o}, 8'h01);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      model_reset();
      for (int i = 0; i < 20; i++) cycle();
      check("midrst_discard", hg0_o, 8'h3F);

      // table of static display cases
      for (int i = 0; i < 10; i++) begin
         bright_i   = vecs[i].bright;
         dp_i       = vecs[i].dp;
         blank_lz_i = vecs[i].blz;
         load(vecs[i].data);
         check($sformatf("tbl%0d_hg0", i), hg0_o, vecs[i].e0);
         check($sformatf("tbl%0d_hg1", i), hg1_o, vecs[i].e1);
      end

      // PWM duty: 4 of every 16 cycles lit, then fully off
      dp_i       = 2'b00;
      blank_lz_i = 1'b0;
      bright_i   = 4'h4;
      load(8'h88);
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         cycle();
         if (hg0_o == 8'h7F) cnt++;
      end
      check("pwm4_lit_count", 8'(cnt), 8'd8);
      bright_i = 4'h0;
      cycle();
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (hg0_o != 8'h00 || hg1_o != 8'h00) cnt++;
      end
      check("pwm0_lit_count", 8'(cnt), 8'd0);

      // blink: half of every 16 cycles blank when enabled, never otherwise
      bright_i = 4'hF;
      blink_i  = 1'b1;
      cycle();
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         cycle();
         if (hg0_o == 8'h00 && hg1_o == 8'h00) cnt++;
      end
`ifdef SEG_DISPLAY_BLINK_EN
      check("blink_blank_count", 8'(cnt), 8'd16);
`else
      check("blink_blank_count", 8'(cnt), 8'd0);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         valid_i    = 1'($urandom_range(0, 1));
         data_i     = 8'($urandom);
         bright_i   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
         dp_i       = 2'($urandom);
         blank_lz_i = 1'($urandom);
         blink_i    = ($urandom_range(0, 7) == 0) ? ~blink_i : blink_i;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
